// File: rtl/player_y_tracker.sv
// Player vertical-position integrator: applies the per-frame signed motion with
// floor/ceiling clamping, tracks GROUND/AIR, and stretches grounded jump presses.
module player_y_tracker #(
    parameter int unsigned Y_GROUND  = 400,
    parameter int unsigned Y_MIN     = 0,
    parameter int unsigned JUMP_HOLD = 8
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [9:0] y_motion,
    input  logic       jump_key,
    output logic       jump_out,
    output logic [9:0] ball_y_pos,
    output logic       on_ground,
    output logic       landed,
    output logic [7:0] air_frames
);

    localparam int unsigned CW = $clog2(JUMP_HOLD + 1);
    localparam logic signed [11:0] GND_S = 12'(Y_GROUND);
    localparam logic signed [11:0] MIN_S = 12'(Y_MIN);

    typedef enum logic {GROUND, AIR} state_t;

    state_t          state_q;
    logic [9:0]      pos_q, pos_d;
    logic            on_ground_q, landed_q, jump_out_q, key_q;
    logic [7:0]      air_q;
    logic [CW-1:0]   cnt_q;
    logic signed [11:0] next_sum;
    logic            hit_floor, hit_ceil, key_rise, ack;

    // 12-bit signed sum leaves headroom for any legal motion, so no wrap is possible
    assign next_sum  = signed'({2'b00, pos_q}) + signed'({{2{y_motion[9]}}, y_motion});
    assign hit_floor = (next_sum >= GND_S);
    assign hit_ceil  = (next_sum <= MIN_S);
    assign key_rise  = jump_key && !key_q;
    assign ack       = (y_motion != '0);

    always_comb begin
        pos_d = next_sum[9:0];
        if (hit_floor) begin
            pos_d = 10'(Y_GROUND);
        end else if (hit_ceil) begin
            pos_d = 10'(Y_MIN);
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q     <= GROUND;
            pos_q       <= 10'(Y_GROUND);
            on_ground_q <= 1'b1;
            landed_q    <= 1'b0;
            jump_out_q  <= 1'b0;
            key_q       <= 1'b0;
            air_q       <= '0;
            cnt_q       <= '0;
        end else begin
            key_q    <= jump_key;
            landed_q <= 1'b0;

            if (jump_out_q) begin
                cnt_q <= cnt_q + CW'(1);
                if (ack || (cnt_q == CW'(JUMP_HOLD - 1))) begin
                    jump_out_q <= 1'b0;
                end
            end else if (key_rise && (state_q == GROUND)) begin
                jump_out_q <= 1'b1;
                cnt_q      <= '0;
            end

            // Position/state update comes last so a take-off overrides a same-cycle jump set
            if (frame_tick) begin
                pos_q <= pos_d;
                case (state_q)
                    GROUND: begin
                        if (!hit_floor) begin
                            state_q     <= AIR;
                            on_ground_q <= 1'b0;
                            air_q       <= 8'd1;
                            jump_out_q  <= 1'b0;
                        end
                    end
                    AIR: begin
                        if (hit_floor) begin
                            state_q     <= GROUND;
                            on_ground_q <= 1'b1;
                            landed_q    <= 1'b1;
                        end else if (air_q != '1) begin
                            air_q <= air_q + 8'd1;
                        end
                    end
                    default: state_q <= GROUND;
                endcase
            end
        end
    end

    assign jump_out   = jump_out_q;
    assign ball_y_pos = pos_q;
    assign on_ground  = on_ground_q;
    assign landed     = landed_q;
    assign air_frames = air_q;

endmodule
